regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file, successor to the single-write 32x32 file in the datapath.
//  Adds a configurable read-port count, a second write port, same-cycle write-to-read bypass, a hardwired zero register,
//  a per-register pending scoreboard for multi-cycle producers, and a sequenced bulk-clear engine.
//  Sits between decode (reads, reservations) and writeback (two retire paths, e.g. ALU and load unit).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//  N_RD     2   number of read ports, 1..4
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never pending
//  BYPASS   1   1: read ports forward same-cycle write data
// PORTS
//  clk        in   1             clock, rising edge
//  rst_n      in   1             reset, asynchronous, active-low
//  rd_addr    in   N_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data    out  N_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  pend_rd    out  N_RD          pending flag of each read address
//  wa_en      in   1             write port A enable
//  wa_addr    in   ADDR_W        write port A address
//  wa_data    in   DATA_W        write port A data
//  wb_en      in   1             write port B enable (higher priority)
//  wb_addr    in   ADDR_W        write port B address
//  wb_data    in   DATA_W        write port B data
//  rsv_en     in   1             reserve (mark pending) register rsv_addr
//  rsv_addr   in   ADDR_W        register to reserve
//  clr_req    in   1             request bulk clear of all registers
//  clr_busy   out  1             bulk clear in progress
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers 0, all pending bits 0, FSM IDLE, clr_busy=0; rd_data reads 0s.
//  Writes: on rising clk, reg[wa_addr]<=wa_data if wa_en; reg[wb_addr]<=wb_data if wb_en.
//   Same address on both ports: port B value stored. ZERO_REG=1: writes to address 0 dropped.
//  Reads: combinational, zero latency. ZERO_REG=1 and addr 0 -> 0 regardless of bypass.
//   BYPASS=1 and FSM IDLE: addr==wb_addr&&wb_en -> wb_data; else addr==wa_addr&&wa_en -> wa_data; else array.
//   BYPASS=0: array value only (write visible next cycle).
//  Scoreboard: pend[rsv_addr] set on edge when rsv_en; pend[x] cleared on edge when either port writes x.
//   Reservation and write to same address in same cycle: set wins (newer producer). Address 0 never set (ZERO_REG=1).
//   pend_rd[k] = pend[rd_addr_k]; with BYPASS=1 also masked to 0 when a same-cycle write targets rd_addr_k.
//  Clear FSM: states IDLE, SWEEP.
//   IDLE: clr_req=1 -> SWEEP next edge; counter<=0; all pending bits cleared on that edge.
//   SWEEP: clr_busy=1; each cycle reg[counter]<=0, counter++; at counter==DEPTH-1 write 0, return to IDLE.
//   clr_busy high exactly DEPTH cycles. During SWEEP: wa/wb writes, rsv_en and clr_req ignored; reads return array, no bypass.
//   Write and clr_req in same IDLE cycle: write performed, then sweep overwrites it.
//  Counter is ADDR_W bits; wrap from DEPTH-1 coincides with SWEEP->IDLE. Reset mid-sweep aborts to IDLE, all regs 0.
// TESTING
//  1 Reset then read all ports addr 0..31 -> all 0, pend_rd=0, clr_busy=0; assert rst_n low mid-cycle -> outputs 0 without clk edge.
//  2 wa_en=1 addr 5 data 0xDEADBEEF, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF (BYPASS=1), next cycle still 0xDEADBEEF; BYPASS=0 build -> 0 then 0xDEADBEEF.
//  3 wa and wb both addr 7, data 0x11/0x22 -> reg7=0x22; write 0x1234 to addr 0 -> reads 0.
//  4 rsv_en addr 9 -> pend_rd=1 next cycle; wb write addr 9 -> cleared; rsv+write addr 9 same cycle -> pend stays 1.
//  5 Fill regs with nonzero, pulse clr_req -> clr_busy high 32 cycles, writes during sweep ignored, all regs 0 after, pending 0.
//  6 rst_n low at sweep cycle 10 -> clr_busy=0 immediately, all regs 0, new clr_req restarts full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: dual write, N_RD combinational reads with optional same-cycle bypass,
// per-register pending scoreboard and a sequenced bulk-clear sweep.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          pend_rd,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic idle;
  logic wa_ok, wb_ok, rsv_ok;

  assign idle     = (state_q == StIdle);
  assign clr_busy = (state_q == StSweep);

  // Writes and reservations to the hardwired zero register are dropped.
  assign wa_ok  = wa_en  && !(ZERO_REG != 0 && wa_addr  == '0);
  assign wb_ok  = wb_en  && !(ZERO_REG != 0 && wb_addr  == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    case (state_q)
      StIdle: begin
        if (wa_ok) regs_d[wa_addr] = wa_data;
        if (wb_ok) regs_d[wb_addr] = wb_data;
        if (wa_en) pend_d[wa_addr] = 1'b0;
        if (wb_en) pend_d[wb_addr] = 1'b0;
        // Set after clear: a reservation names a newer producer than the retiring write.
        if (rsv_ok) pend_d[rsv_addr] = 1'b1;
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
          pend_d  = '0;
        end
      end
      StSweep: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit_a, hit_b;

    assign addr  = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_a = (BYPASS != 0) && idle && wa_en && (wa_addr == addr);
    assign hit_b = (BYPASS != 0) && idle && wb_en && (wb_addr == addr);

    always_comb begin
      if (ZERO_REG != 0 && addr == '0) data = '0;
      else if (hit_b)                  data = wb_data;
      else if (hit_a)                  data = wa_data;
      else                             data = regs_q[addr];
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign pend_rd[k] = pend_q[addr] & ~(hit_a | hit_b);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     pend_rd;
  logic              wa_en, wb_en, rsv_en, clr_req, clr_busy;
  logic [AW-1:0]     wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0]     wa_data, wb_data;
  logic [AW-1:0]     ra [NR];

  always #5 clk = ~clk;

  assign rd_addr = {ra[1], ra[0]};

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .N_RD    (NR),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pend_rd (pend_rd),
    .wa_en   (wa_en),
    .wa_addr (wa_addr),
    .wa_data (wa_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .clr_req (clr_req),
    .clr_busy(clr_busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_pend [DEPTH];
  int            sweep_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    sweep_left = 0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (sweep_left == 0 && wb_en && wb_addr == a) return wb_data;
    if (sweep_left == 0 && wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    logic hit;
    hit = sweep_left == 0 && ((wb_en && wb_addr == a) || (wa_en && wa_addr == a));
    return m_pend[a] && !hit;
  endfunction

  task automatic model_step();
    if (sweep_left > 0) begin
      m_regs[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        sweep_left = DEPTH;
      end else begin
        if (wa_en) m_pend[wa_addr] = 1'b0;
        if (wb_en) m_pend[wb_addr] = 1'b0;
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #2;
    for (int k = 0; k < NR; k++) begin
      check_eq($sformatf("rd%0d@%0d", k, ra[k]), rd_data[k*DW +: DW], exp_rd(ra[k]));
      check_eq($sformatf("pend%0d@%0d", k, ra[k]), 32'(pend_rd[k]), 32'(exp_pend(ra[k])));
    end
    check_eq("clr_busy", 32'(clr_busy), 32'(sweep_left > 0));
    if (clr_busy) busy_cnt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rnd_inputs(input int clr_odds);
    wa_en    = 1'($urandom_range(0, 1));
    wa_addr  = rnd_addr();
    wa_data  = $urandom;
    wb_en    = 1'($urandom_range(0, 1));
    wb_addr  = rnd_addr();
    wb_data  = $urandom;
    rsv_en   = ($urandom_range(0, 3) == 0);
    rsv_addr = rnd_addr();
    clr_req  = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
    ra[0]    = rnd_addr();
    ra[1]    = rnd_addr();
  endtask

  task automatic fill_regs();
    idle_inputs();
    for (int a = 1; a < DEPTH; a++) begin
      wa_en = 1; wa_addr = AW'(a); wa_data = 32'h0101_0101 * a + 32'h5;
      cycle();
    end
    idle_inputs();
  endtask

  task automatic async_reset_check(input string tag);
    idle_inputs();
    ra[0] = AW'(31);
    ra[1] = AW'(20);
    #1 rst_n = 0;
    #1;
    check_eq({tag, "_rd0"}, rd_data[0 +: DW], '0);
    check_eq({tag, "_rd1"}, rd_data[DW +: DW], '0);
    check_eq({tag, "_pend"}, 32'(pend_rd), '0);
    check_eq({tag, "_busy"}, 32'(clr_busy), '0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    ra[0] = '0;
    ra[1] = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset contents on every address
    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a);
      ra[1] = AW'(DEPTH - 1 - a);
      cycle();
    end

    // Bypass then registered value
    wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF; ra[0] = 5'd5;
    cycle();
    idle_inputs();
    cycle();
    check_eq("t2_hold", rd_data[0 +: DW], 32'hDEAD_BEEF);

    // Port B wins on collision; zero register ignores writes
    wa_en = 1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h22;
    cycle();
    idle_inputs();
    ra[0] = 5'd7;
    cycle();
    check_eq("t3_reg7", rd_data[0 +: DW], 32'h22);
    wa_en = 1; wa_addr = '0; wa_data = 32'h1234; ra[1] = '0;
    cycle();
    idle_inputs();
    cycle();
    check_eq("t3_zero", rd_data[DW +: DW], '0);

    // Scoreboard
    ra[0] = 5'd9;
    rsv_en = 1; rsv_addr = 5'd9;
    cycle();
    idle_inputs();
    cycle();
    check_eq("t4_pend_set", 32'(pend_rd[0]), 32'd1);
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'hABCD;
    cycle();
    idle_inputs();
    cycle();
    check_eq("t4_pend_clr", 32'(pend_rd[0]), 32'd0);
    rsv_en = 1; rsv_addr = 5'd9; wa_en = 1; wa_addr = 5'd9; wa_data = 32'h77;
    cycle();
    idle_inputs();
    cycle();
    check_eq("t4_set_wins", 32'(pend_rd[0]), 32'd1);

    // Full sweep with writes attempted during it
    fill_regs();
    rsv_en = 1; rsv_addr = 5'd3;
    cycle();
    idle_inputs();
    busy_cnt = 0;
    wa_en = 1; wa_addr = 5'd12; wa_data = 32'hCAFE; clr_req = 1;
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      rnd_inputs(0);
      clr_req = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();
    check_eq("t5_busy_len", 32'(busy_cnt), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a);
      ra[1] = AW'(a);
      cycle();
    end

    // Reset mid-sweep, then a fresh full sweep
    fill_regs();
    clr_req = 1;
    cycle();
    idle_inputs();
    repeat (10) cycle();
    async_reset_check("t6_rst");
    busy_cnt = 0;
    clr_req = 1;
    cycle();
    idle_inputs();
    repeat (DEPTH + 4) cycle();
    check_eq("t6_busy_len", 32'(busy_cnt), 32'(DEPTH));

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_inputs(60);
      cycle();
    end
    async_reset_check("rnd_rst");
    for (int i = 0; i < 500; i++) begin
      rnd_inputs(60);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
